// File: rtl/sm_imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// sm_imem_loader_pkg
//  Shared definitions for the instruction-memory loader: the frame header byte
//  and the 3-bit loader state encoding. Imported by the RTL and by the bench.
//  No ports.
// -----------------------------------------------------------------------------
package sm_imem_loader_pkg;

   localparam logic [7:0] SM_LDR_HDR = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } ldr_state_t;

endpackage

// File: rtl/sm_word_assembler.sv
// -----------------------------------------------------------------------------
// sm_word_assembler
//  Packs four accepted bytes into one little-endian 32-bit word. The first
//  byte of a group ends up in word[7:0].
//  Ports:
//   clk, rst      clock, synchronous active-high reset
//   clear         frame start: drop any partial word
//   byte_valid    byte_data is accepted this cycle
//   byte_data     stream byte
//   word_valid    one-cycle pulse, the cycle after the 4th byte of a group
//   word          assembled word (valid while word_valid is high)
// -----------------------------------------------------------------------------
module sm_word_assembler (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        word_valid,
   output logic [31:0] word
);

   logic [1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt        <= 2'd0;
         word       <= 32'd0;
         word_valid <= 1'b0;
      end else begin
         word_valid <= byte_valid && (cnt == 2'd3);
         if (byte_valid) begin
            cnt  <= cnt + 2'd1;
            // Shift in from the top so the oldest byte lands in the LSBs.
            word <= {byte_data, word[31:8]};
         end
      end
   end

endmodule

// File: rtl/sm_imem_loader.sv
// -----------------------------------------------------------------------------
// sm_imem_loader
//  Receives a framed byte stream (A5, L, (L+1)*4 data bytes LSB first,
//  optional checksum), writes the words into instruction RAM starting at
//  address 0 and holds the CPU in reset until a complete image is loaded.
//  Build option: define SM_LOADER_CHECKSUM_EN to require a trailing checksum
//  byte (sum of data bytes mod 256).
//  Handshake: a byte transfers on a cycle where in_valid && in_ready; in_valid
//  and in_data must stay stable until that cycle. in_ready drops during rst and
//  on every RAM write cycle.
//  Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data/in_valid    stream byte and its valid
//   in_ready            loader can take a byte this cycle
//   we/waddr/wdata      RAM write strobe (one cycle), word address, word data
//   cpu_rst_n           CPU reset, released only in the done state
//   done, error         load complete / frame error, both held until next header
//  ADDR_WIDTH is supported from 1 to 8 (the length byte limits an image to 256
//  words).
// -----------------------------------------------------------------------------
module sm_imem_loader
   import sm_imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int TIMEOUT    = 1000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  we,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic [31:0]           wdata,
   output logic                  cpu_rst_n,
   output logic                  done,
   output logic                  error
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int TW    = $clog2(TIMEOUT + 1);

   ldr_state_t    state, next_state;
   logic          xfer, in_frame, frame_start, timed_out, last_word;
   logic          word_valid;
   logic [31:0]   word;
   logic [7:0]    widx, last_idx;
   logic [TW-1:0] tcnt;
`ifdef SM_LOADER_CHECKSUM_EN
   logic [7:0]    csum;
`endif

   assign in_ready    = !rst && !word_valid;
   assign xfer        = in_valid && in_ready;
   assign in_frame    = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
   // Headers only resync outside a frame; inside one, 0xA5 is ordinary data.
   assign frame_start = xfer && !in_frame && (in_data == SM_LDR_HDR);
   assign timed_out   = in_frame && !xfer && (tcnt == TW'(TIMEOUT - 1));
   assign last_word   = word_valid && (widx == last_idx);

   assign we        = word_valid;
   assign wdata     = word;
   assign waddr     = widx[ADDR_WIDTH-1:0];
   assign done      = (state == ST_DONE);
   assign cpu_rst_n = (state == ST_DONE);
   assign error     = (state == ST_ERR);

   sm_word_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .clear      (frame_start),
      .byte_valid (xfer && (state == ST_DATA)),
      .byte_data  (in_data),
      .word_valid (word_valid),
      .word       (word)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (frame_start) next_state = ST_LEN;
         end
         ST_LEN: begin
            // L+1 words fit only when L < DEPTH.
            if (xfer) next_state = ({24'd0, in_data} >= DEPTH) ? ST_ERR : ST_DATA;
         end
         ST_DATA: begin
`ifdef SM_LOADER_CHECKSUM_EN
            if (last_word) next_state = ST_CSUM;
`else
            if (last_word) next_state = ST_DONE;
`endif
         end
`ifdef SM_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (xfer) next_state = (in_data == csum) ? ST_DONE : ST_ERR;
         end
`endif
         default: next_state = ST_IDLE;
      endcase
      if (timed_out) next_state = ST_ERR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         widx     <= 8'd0;
         last_idx <= 8'd0;
         tcnt     <= '0;
      end else begin
         // The index stays on the last word instead of running past it.
         if (frame_start)                  widx <= 8'd0;
         else if (word_valid && !last_word) widx <= widx + 8'd1;

         if ((state == ST_LEN) && xfer) last_idx <= in_data;

         if (!in_frame || xfer) tcnt <= '0;
         else                   tcnt <= tcnt + TW'(1);
      end
   end

`ifdef SM_LOADER_CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         csum <= 8'd0;
      end else if (frame_start) begin
         csum <= 8'd0;
      end else if ((state == ST_DATA) && xfer) begin
         csum <= csum + in_data;
      end
   end
`endif

endmodule

// File: tb/tb_sm_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_sm_imem_loader
//  Directed bench for sm_imem_loader (ADDR_WIDTH=6, TIMEOUT=1000). Follows the
//  SM_LOADER_CHECKSUM_EN build option: checksum bytes are sent only when it is
//  defined.
// -----------------------------------------------------------------------------
module tb_sm_imem_loader;
   import sm_imem_loader_pkg::*;

   localparam int AW      = 6;
   localparam int TIMEOUT = 1000;
   localparam int W       = AW + 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    in_data = 8'd0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          we;
   logic [AW-1:0] waddr;
   logic [31:0]   wdata;
   logic          cpu_rst_n;
   logic          done;
   logic          error;

   int n_cmp = 0;
   int n_err = 0;
   logic [W-1:0] exp_q[$];

   sm_imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .cpu_rst_n (cpu_rst_n),
      .done      (done),
      .error     (error)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish within 300000 time units");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard: every RAM write ----------------
   always @(negedge clk) begin
      if (we === 1'b1) begin
         n_cmp++;
         if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_on_we: in_ready=%b want 0", in_ready);
         end
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, none expected", waddr, wdata);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if ({waddr, wdata} !== e) begin
               n_err++;
               $display("FAIL write: got addr=%0d data=%h want addr=%0d data=%h",
                        waddr, wdata, e[W-1:32], e[31:0]);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b);
      int waited;
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      waited   = 0;
      while (in_ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (in_ready !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL ready_timeout: byte %h not accepted, in_ready=%b want 1", b, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_csum(input logic [7:0] cs);
`ifdef SM_LOADER_CHECKSUM_EN
      send_byte(cs);
`else
      if (cs == 8'hFF) $display("note: checksum byte not used in this build");
`endif
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   task automatic check_flags(input string name, input logic d, input logic e, input logic r);
      // name-tagged inline checks of the three status outputs
      n_cmp++;
      if (done !== d) begin
         n_err++; $display("FAIL %s_done: got %b want %b", name, done, d);
      end
      n_cmp++;
      if (error !== e) begin
         n_err++; $display("FAIL %s_error: got %b want %b", name, error, e);
      end
      n_cmp++;
      if (cpu_rst_n !== r) begin
         n_err++; $display("FAIL %s_cpu_rst_n: got %b want %b", name, cpu_rst_n, r);
      end
   endtask

   task automatic send_single_word_frame();
      exp_q.push_back({6'd0, 32'h2400_0013});
      send_byte(SM_LDR_HDR); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h24);
      send_csum(8'h37);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      n_cmp++;
      if (we !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", we); end
      n_cmp++;
      if (waddr !== 6'd0) begin n_err++; $display("FAIL rst_waddr: got %0d want 0", waddr); end
      n_cmp++;
      if (wdata !== 32'd0) begin n_err++; $display("FAIL rst_wdata: got %h want 0", wdata); end
      check_flags("rst", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %b want 1", in_ready); end
      check_flags("post_rst", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_discard_then_load();
      send_byte(8'h11);
      send_byte(8'h22);
      settle();
      check_flags("discard", 1'b0, 1'b0, 1'b0);
      send_single_word_frame();
      settle();
      check_flags("single", 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL single_writes: %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_reload();
      send_byte(SM_LDR_HDR);
      // The header clears done and re-resets the CPU as the state changes.
      check_flags("reload_hdr", 1'b0, 1'b0, 1'b0);
      exp_q.push_back({6'd0, 32'h2400_0013});
      send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h24);
      send_csum(8'h37);
      settle();
      check_flags("reload", 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_two_words();
      exp_q.push_back({6'd0, 32'h2402_000A});
      exp_q.push_back({6'd1, 32'h0000_0000});
      send_byte(SM_LDR_HDR); send_byte(8'h01);
      send_byte(8'h0A); send_byte(8'h00); send_byte(8'h02); send_byte(8'h24);
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_csum(8'h30);
      settle();
      check_flags("two_words", 1'b1, 1'b0, 1'b1);
      n_cmp++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL two_words_writes: %0d pending want 0", exp_q.size()); end
   endtask

   task automatic test_a5_as_data();
      exp_q.push_back({6'd0, 32'h0100_A5A5});
      send_byte(SM_LDR_HDR); send_byte(8'h00);
      send_byte(SM_LDR_HDR); send_byte(SM_LDR_HDR); send_byte(8'h00); send_byte(8'h01);
      send_csum(8'h4B);
      settle();
      check_flags("a5_data", 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_len_overflow();
      send_byte(SM_LDR_HDR);
      send_byte(8'h40);
      check_flags("len_ovf", 1'b0, 1'b1, 1'b0);
      send_byte(8'h00);
      send_byte(8'h01);
      settle();
      check_flags("len_ovf_hold", 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_bad_checksum();
`ifdef SM_LOADER_CHECKSUM_EN
      exp_q.push_back({6'd0, 32'h2400_0013});
      send_byte(SM_LDR_HDR); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h24);
      send_byte(8'h00);
      settle();
      check_flags("bad_csum", 1'b0, 1'b1, 1'b0);
`endif
   endtask

   task automatic test_timeout();
      send_byte(SM_LDR_HDR); send_byte(8'h00);
      send_byte(8'h13); send_byte(8'h00);
      // One idle cycle short of the limit: still loading.
      repeat (TIMEOUT - 1) @(posedge clk);
      #1;
      check_flags("timeout_edge", 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_flags("timeout", 1'b0, 1'b1, 1'b0);
      send_single_word_frame();
      settle();
      check_flags("recover", 1'b1, 1'b0, 1'b1);
   endtask

   task automatic test_abort();
      exp_q.push_back({6'd0, 32'h1122_3344});
      send_byte(SM_LDR_HDR); send_byte(8'h01);
      send_byte(8'h44); send_byte(8'h33); send_byte(8'h22); send_byte(8'h11);
      settle();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0) begin n_err++; $display("FAIL abort_in_ready: got %b want 0", in_ready); end
      check_flags("abort", 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      settle();
      check_flags("abort_idle", 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (exp_q.size() != 0) begin n_err++; $display("FAIL final_writes: %0d pending want 0", exp_q.size()); end
   endtask

   // ---------------- sequence + report ----------------
   initial begin
      test_reset();
      test_discard_then_load();
      test_reload();
      test_two_words();
      test_a5_as_data();
      test_len_overflow();
      test_bad_checksum();
      test_timeout();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
